fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of synchronous_fifo among
//  NUM_REQ producers. Sits between producer blocks and the FIFO (w_en/data_in/full).
//  Each producer uses a valid/ack handshake; the arbiter sequences one write per cycle
//  and never writes while the FIFO reports full.
// PARAMETERS
//  NUM_REQ    4  number of producers (2..8)
//  DATA_WIDTH 8  data width; matches FIFO data_in
//  MAX_BURST  4  max consecutive beats per grant (used only with FIFO_ARB_BURST_EN)
// PORTS
//  clk         in  1                   clock, all logic on posedge
//  rst_n       in  1                   synchronous, active-high reset (1 = reset)
//  req_i       in  NUM_REQ             per-producer request; held until ack
//  data_i      in  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DW +: DW]
//  gnt_o       out NUM_REQ             one-hot registered grant
//  ack_o       out NUM_REQ             1-cycle pulse: data_i[i] written this cycle
//  fifo_full_i in  1                   FIFO full flag
//  fifo_w_en_o out 1                   FIFO write enable (= |ack_o)
//  fifo_data_o out DATA_WIDTH          FIFO write data (granted producer's data)
//  busy_o      out 1                   1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, gnt_o=0, ack_o=0, fifo_w_en_o=0, fifo_data_o=0, busy_o=0,
//   rr pointer=NUM_REQ-1 (producer 0 highest priority first), beat_cnt=0.
//  rr_pick(mask): first set bit of mask searching from pointer+1 upward, wrapping.
//  IDLE: if |req_i, gnt_q<=rr_pick(req_i), ->SERVE; else stay. No writes in IDLE.
//  SERVE (gnt_q = one-hot g):
//   - ack_o[g]=fifo_w_en_o= req_i[g] & ~fifo_full_i (combinational from gnt_q, full).
//   - fifo_data_o = data_i[g] whenever in SERVE; 0 in IDLE.
//   - full high: no write, grant held, state unchanged (stall indefinitely).
//   - on ack: pointer<=g; next grant = rr_pick(req_i) with new pointer (same-cycle
//     req_i, so the just-served producer is lowest priority but is re-granted if it is
//     the only requester); if no req_i bit set -> IDLE, gnt_q<=0.
//   - req_i[g] dropped without ack (protocol violation): ->IDLE next cycle, no write.
//  Latency: req from IDLE -> gnt_o next cycle, write that same cycle if not full.
//   Back-to-back producers sustain 1 write/cycle; no bubble between grants.
//  ack_o is never asserted for a non-granted producer; at most one ack_o bit high.
//  Reset mid-operation: all outputs return to reset values next edge; in-flight
//   request not written (producer retries).
// CONFIGURATION
//  FIFO_ARB_BURST_EN defined: on ack, if req_i[g] still high and beat_cnt+1<MAX_BURST,
//   grant stays on g (beat_cnt++); else rotate as above, beat_cnt<=0. beat_cnt
//   width $clog2(MAX_BURST+1); stall cycles (full) do not count as beats.
//  Not defined: grant rotates after every ack; beat_cnt logic absent; MAX_BURST unused.
// TESTING
//  1 Reset: rst_n=1 two cycles with req_i=4'hF -> gnt_o=0, fifo_w_en_o=0, busy_o=0.
//  2 Single: req_i=4'b0100, data 8'hA5, full=0 -> gnt_o=4'b0100 cycle+1, write 8'hA5
//    same cycle, ack_o[2] one cycle, IDLE after req drops.
//  3 Fairness: req_i=4'hF held 8 acks, no burst -> grant order 0,1,2,3,0,1,2,3,
//    w_en high 8 consecutive cycles.
//  4 Full stall: granted producer 1, full=1 for 5 cycles -> w_en=0, gnt_o=4'b0010 held;
//    full drops -> write next cycle, data unchanged.
//  5 Burst (FIFO_ARB_BURST_EN, MAX_BURST=4): req_i=4'b0011 held -> 4 writes from 0,
//    then 4 from 1; without macro alternates 0,1,0,1.
//  6 Reset mid-stall: assert rst_n during test 4 stall -> outputs at reset values next
//    edge, no FIFO write issued.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle for fifo_wr_arbiter.
// The slave modport is the arbiter's view; the master modport belongs to the
// environment that drives the producer requests and the FIFO full flag.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            ack_o;
  logic                          fifo_full_i;
  logic                          fifo_w_en_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          busy_o;

  modport slave (
    input  req_i, data_i, fifo_full_i,
    output gnt_o, ack_o, fifo_w_en_o, fifo_data_o, busy_o
  );

  modport master (
    output req_i, data_i, fifo_full_i,
    input  gnt_o, ack_o, fifo_w_en_o, fifo_data_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A registered one-hot grant selects a producer; the write (ack) fires
// combinationally whenever that producer is requesting and the FIFO is not
// full, so back-to-back grants sustain one write per clock.
// Optional feature: define FIFO_ARB_BURST_EN to let a granted producer keep
// the port for up to MAX_BURST consecutive beats before rotation.
// Note: rst_n is active-high despite its name (1 = reset).
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Elaboration-time guard on the supported configuration range
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (MAX_BURST < 1)) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported NUM_REQ/MAX_BURST");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_busy;
`ifdef FIFO_ARB_BURST_EN
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  logic [BEAT_W-1:0]   r_beat;
`endif

  logic [NUM_REQ-1:0]    w_ack;
  logic [PTR_W-1:0]      w_gidx;
  logic                  w_req_g;
  logic [NUM_REQ-1:0]    w_pick_idle;
  logic [NUM_REQ-1:0]    w_pick_rot;
  logic [DATA_WIDTH-1:0] w_masked [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data;

  // First set bit of mask strictly after ptr, wrapping around
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] mask,
    input logic [PTR_W-1:0]   ptr
  );
    logic [NUM_REQ-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && mask[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return pick;
  endfunction

  // Per-producer ack gating and data masking by the one-hot grant
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_ack[gi]    = r_gnt[gi] & bus.req_i[gi] & ~bus.fifo_full_i;
    assign w_masked[gi] = bus.data_i[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_gnt[gi]}};
  end

  // OR-reduce the masked lanes; zero when nothing is granted (IDLE)
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_data = w_data | w_masked[k];
    end
  end

  // Encode the one-hot grant into an index for the pointer update
  always_comb begin
    w_gidx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_gnt[k]) begin
        w_gidx = PTR_W'(k);
      end
    end
  end

  assign w_req_g     = |(bus.req_i & r_gnt);
  assign w_pick_idle = rr_pick(bus.req_i, r_ptr);
  // Candidate after an ack: the just-served producer becomes lowest priority
  assign w_pick_rot  = rr_pick(bus.req_i, w_gidx);

  // Arbitration state machine: grant, rotation pointer and busy flag
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_busy  <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      r_beat  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req_i) begin
            r_gnt   <= w_pick_idle;
            r_state <= SERVE;
            r_busy  <= 1'b1;
          end
        end
        SERVE: begin
          if (!w_req_g) begin
            // Granted producer withdrew without being written: give up the port
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
            r_beat  <= '0;
`endif
          end else if (!bus.fifo_full_i) begin
            // A write happens this cycle
            r_ptr <= w_gidx;
`ifdef FIFO_ARB_BURST_EN
            if ((int'(r_beat) + 1) < MAX_BURST) begin
              r_beat <= r_beat + BEAT_W'(1);
            end else begin
              r_beat <= '0;
              r_gnt  <= w_pick_rot;
              if (~|bus.req_i) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
`else
            r_gnt <= w_pick_rot;
            if (~|bus.req_i) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
`endif
          end
          // FIFO full with request still held: stall, everything holds
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.ack_o       = w_ack;
  assign bus.fifo_w_en_o = |w_ack;
  assign bus.fifo_data_o = w_data;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a cycle table covering reset, a single
// request, a full stall and a reset during a stall, followed by held-request
// sequences for fairness and burst behaviour. Every FIFO write is checked
// against a scoreboard of expected {grant, data} entries.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       wen;
    logic       busy;
    logic [7:0] data;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] sb_q [$];
  bit          mon_en   = 1'b0;
  logic [7:0]  prod_data [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rst, input logic [3:0] req, input logic full,
                               input logic [3:0] gnt, input logic [3:0] ack, input logic wen,
                               input logic busy, input logic [7:0] data);
    vec_t v;
    v.rst = rst; v.req = req; v.full = full; v.gnt = gnt;
    v.ack = ack; v.wen = wen; v.busy = busy; v.data = data;
    return v;
  endfunction

  // Write monitor: every FIFO write must match the head of the scoreboard
  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (mon_en) begin
      check("wen_eq_or_ack", 32'(bus.fifo_w_en_o), 32'(|bus.ack_o));
      if (bus.fifo_w_en_o === 1'b1) begin
        check("ack_only_granted", 32'(bus.ack_o), 32'(bus.gnt_o));
        $display("write: gnt=%b data=0x%02h", bus.gnt_o, bus.fifo_data_o);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got gnt=%b data=0x%02h, expected no write",
                   bus.gnt_o, bus.fifo_data_o);
        end else begin
          e = sb_q.pop_front();
          check("wr_gnt", 32'(bus.gnt_o), 32'(e[11:8]));
          check("wr_data", 32'(bus.fifo_data_o), 32'(e[7:0]));
        end
      end
    end
  end

  // Hold req for eight writes and expect the given producer order
  task automatic run_held(input logic [3:0] req, input int order [8], input string tag);
    @(posedge clk); #1;
    bus.req_i = req;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back({4'(4'b0001 << order[i]), prod_data[order[i]]});
    end
    @(negedge clk);
    check($sformatf("%s_idle_no_write", tag), 32'(bus.fifo_w_en_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("%s_wen_%0d", tag, i), 32'(bus.fifo_w_en_o), 32'd1);
    end
    @(posedge clk); #1;
    bus.req_i = 4'h0;
    @(negedge clk);
    check($sformatf("%s_drop_wen", tag), 32'(bus.fifo_w_en_o), 32'd0);
    @(negedge clk);
    check($sformatf("%s_end_busy", tag), 32'(bus.busy_o), 32'd0);
  endtask

  int fair_order  [8];
  int burst_order [8];

  initial begin
    prod_data[0] = 8'h3C;
    prod_data[1] = 8'h5A;
    prod_data[2] = 8'hA5;
    prod_data[3] = 8'hD3;

    //               rst req   full gnt   ack   wen busy data
    vecs[0]  = mkv(1, 4'hF, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[1]  = mkv(1, 4'hF, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[2]  = mkv(0, 4'h4, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[3]  = mkv(0, 4'h4, 0, 4'h4, 4'h4, 1, 1, 8'hA5);
    vecs[4]  = mkv(0, 4'h0, 0, 4'h4, 4'h0, 0, 1, 8'hA5);
    vecs[5]  = mkv(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[6]  = mkv(0, 4'h2, 1, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[7]  = mkv(0, 4'h2, 1, 4'h2, 4'h0, 0, 1, 8'h5A);
    vecs[8]  = mkv(0, 4'h2, 1, 4'h2, 4'h0, 0, 1, 8'h5A);
    vecs[9]  = mkv(0, 4'h2, 1, 4'h2, 4'h0, 0, 1, 8'h5A);
    vecs[10] = mkv(0, 4'h2, 1, 4'h2, 4'h0, 0, 1, 8'h5A);
    vecs[11] = mkv(0, 4'h2, 0, 4'h2, 4'h2, 1, 1, 8'h5A);
    vecs[12] = mkv(0, 4'h0, 0, 4'h2, 4'h0, 0, 1, 8'h5A);
    vecs[13] = mkv(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[14] = mkv(0, 4'h8, 1, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[15] = mkv(0, 4'h8, 1, 4'h8, 4'h0, 0, 1, 8'hD3);
    vecs[16] = mkv(1, 4'h8, 1, 4'h8, 4'h0, 0, 1, 8'hD3);
    vecs[17] = mkv(0, 4'h8, 0, 4'h0, 4'h0, 0, 0, 8'h00);
    vecs[18] = mkv(0, 4'h8, 0, 4'h8, 4'h8, 1, 1, 8'hD3);
    vecs[19] = mkv(0, 4'h0, 0, 4'h8, 4'h0, 0, 1, 8'hD3);
    vecs[20] = mkv(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 8'h00);

    fair_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef FIFO_ARB_BURST_EN
    burst_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    burst_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif

    rst_n           = 1'b1;
    bus.req_i       = 4'hF;
    bus.data_i      = {prod_data[3], prod_data[2], prod_data[1], prod_data[0]};
    bus.fifo_full_i = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      rst_n           = vecs[k].rst;
      bus.req_i       = vecs[k].req;
      bus.fifo_full_i = vecs[k].full;
      if (vecs[k].wen) sb_q.push_back({vecs[k].gnt, vecs[k].data});
      @(negedge clk);
      check($sformatf("v%0d_gnt", k),  32'(bus.gnt_o),       32'(vecs[k].gnt));
      check($sformatf("v%0d_ack", k),  32'(bus.ack_o),       32'(vecs[k].ack));
      check($sformatf("v%0d_wen", k),  32'(bus.fifo_w_en_o), 32'(vecs[k].wen));
      check($sformatf("v%0d_busy", k), 32'(bus.busy_o),      32'(vecs[k].busy));
      check($sformatf("v%0d_data", k), 32'(bus.fifo_data_o), 32'(vecs[k].data));
    end

    run_held(4'hF, fair_order, "fair");
    run_held(4'h3, burst_order, "burst");

    @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
